// File: rtl/pwm_pkg.sv
// Shared constants and the duty clamp used by the complementary PWM generator.
package pwm_pkg;

    localparam int unsigned DataWidthDefault = 16;
    localparam int unsigned CntWidthDefault  = 16;
    localparam int unsigned DeadTimeDefault  = 4;

    // Clamp result: duty in CntWidthDefault+1 bits (can reach period+1) plus out-of-range flag.
    typedef struct packed {
        logic [CntWidthDefault:0] duty;
        logic                     clamped;
    } duty_clamp_t;

    // Negative duty maps to 0, duty above period+1 maps to period+1. Sized to the default
    // widths, so generator instances must not use wider duty or period words.
    function automatic duty_clamp_t clamp_duty(
        input logic signed [DataWidthDefault-1:0] duty,
        input logic        [CntWidthDefault-1:0]  period
    );
        duty_clamp_t              res;
        logic [CntWidthDefault:0] limit;
        logic [CntWidthDefault:0] duty_u;
        limit       = {1'b0, period} + (CntWidthDefault + 1)'(1);
        duty_u      = (CntWidthDefault + 1)'(duty);
        res.duty    = '0;
        res.clamped = 1'b0;
        if (duty[DataWidthDefault-1]) begin
            res.clamped = 1'b1;
        end else if (duty_u > limit) begin
            res.duty    = limit;
            res.clamped = 1'b1;
        end else begin
            res.duty    = duty_u;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_generator_dead_time_gate.sv
// Dead-time gate: output asserts after src has been high DEAD_TIME+1 consecutive cycles and
// drops on the cycle after src falls.
module dead_time_gate
    import pwm_pkg::*;
#(
    parameter int unsigned DEAD_TIME = DeadTimeDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic src,
    output logic out
);

    localparam int unsigned RunWidth = $clog2(DEAD_TIME + 2);
    localparam logic [RunWidth-1:0] RunMax = RunWidth'(DEAD_TIME + 1);

    logic [RunWidth-1:0] run_q;
    logic [RunWidth-1:0] run_d;
    logic                out_d;

    // Saturating run-length of src; output decodes the saturated value.
    always_comb begin
        run_d = '0;
        out_d = 1'b0;
        if (src) begin
            run_d = (run_q == RunMax) ? RunMax : run_q + RunWidth'(1);
            out_d = (run_d == RunMax);
        end
    end

    // Run-length and output registers; clear forces an immediate stop.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            run_q <= '0;
            out   <= 1'b0;
        end else begin
            run_q <= run_d;
            out   <= out_d;
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// Complementary PWM generator with dead-time insertion. Period and duty are shadow-latched
// only at period boundaries so every period is glitch-free.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DataWidthDefault,
    parameter int unsigned CNT_WIDTH  = CntWidthDefault,
    parameter int unsigned DEAD_TIME  = DeadTimeDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [CNT_WIDTH-1:0]  period,
    input  logic [DATA_WIDTH-1:0] duty,
    output logic                  pwm_p,
    output logic                  pwm_n,
    output logic                  cycle_start,
    output logic                  duty_clamped
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] period_l_q;
    logic [CNT_WIDTH:0]   duty_l_q;
    logic                 running_q;
    logic                 raw_q;

    duty_clamp_t clamp_res;
    logic        load;
    logic        gate_clear;
    logic        src_n;

    // Clamp against the incoming period; load on start or on wrap.
    always_comb begin
        clamp_res  = clamp_duty(DataWidthDefault'($signed(duty)), CntWidthDefault'(period));
        load       = !running_q || (cnt_q == period_l_q);
        gate_clear = !en;
        src_n      = running_q && !raw_q;
    end

    // Period counter, shadow registers and the raw duty comparator.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            period_l_q   <= '0;
            duty_l_q     <= '0;
            running_q    <= 1'b0;
            raw_q        <= 1'b0;
            cycle_start  <= 1'b0;
            duty_clamped <= 1'b0;
        end else if (!en) begin
            // Immediate stop; shadow registers and the clamp flag are kept.
            cnt_q       <= '0;
            running_q   <= 1'b0;
            raw_q       <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            running_q <= 1'b1;
            raw_q     <= running_q && ({1'b0, cnt_q} < duty_l_q);
            if (load) begin
                cnt_q        <= '0;
                cycle_start  <= 1'b1;
                period_l_q   <= period;
                duty_l_q     <= clamp_res.duty;
                duty_clamped <= clamp_res.clamped;
            end else begin
                cnt_q       <= cnt_q + CNT_WIDTH'(1);
                cycle_start <= 1'b0;
            end
        end
    end

    dead_time_gate #(
        .DEAD_TIME (DEAD_TIME)
    ) u_gate_p (
        .clk   (clk),
        .rst   (rst),
        .clear (gate_clear),
        .src   (raw_q),
        .out   (pwm_p)
    );

    // Low side only counts while running, so it stays off after a stop.
    dead_time_gate #(
        .DEAD_TIME (DEAD_TIME)
    ) u_gate_n (
        .clk   (clk),
        .rst   (rst),
        .clear (gate_clear),
        .src   (src_n),
        .out   (pwm_n)
    );

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: two instances (DEAD_TIME 0 and 2) share stimulus.
module tb_pwm_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] period;
    logic [15:0] duty;

    logic p0, n0, cs0, cl0;
    logic p2, n2, cs2, cl2;

    int checks = 0;
    int errors = 0;

    string tag_q[$];
    int    exp_q[$];

    int cp0, cn0, cp2, cn2, ccs, clow0, clow2;
    int ovl = 0;
    int steps;

    always #5 clk = ~clk;

    pwm_generator #(
        .DATA_WIDTH (16),
        .CNT_WIDTH  (16),
        .DEAD_TIME  (0)
    ) dut0 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .period       (period),
        .duty         (duty),
        .pwm_p        (p0),
        .pwm_n        (n0),
        .cycle_start  (cs0),
        .duty_clamped (cl0)
    );

    pwm_generator #(
        .DATA_WIDTH (16),
        .CNT_WIDTH  (16),
        .DEAD_TIME  (2)
    ) dut2 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .period       (period),
        .duty         (duty),
        .pwm_p        (p2),
        .pwm_n        (n2),
        .cycle_start  (cs2),
        .duty_clamped (cl2)
    );

    // Complementary outputs must never overlap.
    always @(negedge clk) begin
        if ((p0 && n0) || (p2 && n2)) ovl++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input string tag, input int exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic pop_check(input int obs);
        string tag;
        int    exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0d expected none", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            end
        end
    endtask

    task automatic clr();
        cp0 = 0; cn0 = 0; cp2 = 0; cn2 = 0; ccs = 0; clow0 = 0; clow2 = 0;
    endtask

    task automatic measure(input int n);
        for (int i = 0; i < n; i++) begin
            if (p0) cp0++;
            if (n0) cn0++;
            if (p2) cp2++;
            if (n2) cn2++;
            if (cs0) ccs++;
            if (!p0 && !n0) clow0++;
            if (!p2 && !n2) clow2++;
            step(1);
        end
    endtask

    // Steps until the next cycle_start, bounded.
    task automatic steps_to_cs(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!cs0 && n < 40);
    endtask

    // Called at the first sample after a restart edge.
    task automatic restart_checks(input string pre);
        logic [3:0] lp0;
        logic [3:0] lp2;
        push({pre, "_cs"}, 3);
        pop_check(int'({cs0, cs2}));
        push({pre, "_lag_p0"}, 7);
        push({pre, "_lag_p2"}, 1);
        for (int k = 0; k < 4; k++) begin
            step(1);
            lp0 = {lp0[2:0], p0};
            lp2 = {lp2[2:0], p2};
        end
        pop_check(int'(lp0));
        pop_check(int'(lp2));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; period = 16'd9; duty = 16'd3;
        step(3);
        push("reset_outs", 0);
        pop_check(int'({p0, n0, cs0, cl0, p2, n2, cs2, cl2}));

        // Basic PWM, period 9, duty 3.
        rst = 1'b0;
        step(1);
        en = 1'b1;
        step(1);
        push("first_cs", 3);
        pop_check(int'({cs0, cs2}));
        step(10);
        push("cs_period10", 3);
        pop_check(int'({cs0, cs2}));
        push("basic_p", 3); push("basic_n", 7); push("dt_p", 1); push("dt_n", 5);
        push("basic_gap", 0); push("dt_gap", 4); push("basic_clamp", 0);
        clr(); measure(10);
        pop_check(cp0); pop_check(cn0); pop_check(cp2); pop_check(cn2);
        pop_check(clow0); pop_check(clow2); pop_check(int'({cl0, cl2}));
        push("cs_count30", 3);
        clr(); measure(30);
        pop_check(ccs);

        // Negative duty clamps to 0.
        en = 1'b0; step(1);
        duty = 16'hFFFB; en = 1'b1; step(1);
        step(20);
        push("neg_p0", 0); push("neg_n0", 10); push("neg_p2", 0); push("neg_n2", 10);
        push("neg_clamp", 3);
        clr(); measure(10);
        pop_check(cp0); pop_check(cn0); pop_check(cp2); pop_check(cn2);
        pop_check(int'({cl0, cl2}));

        // Large duty clamps to period+1.
        en = 1'b0; step(1);
        duty = 16'h7FFF; en = 1'b1; step(1);
        restart_checks("pos");
        step(16);
        push("pos_p0", 10); push("pos_n0", 0); push("pos_p2", 10); push("pos_n2", 0);
        push("pos_clamp", 3);
        clr(); measure(10);
        pop_check(cp0); pop_check(cn0); pop_check(cp2); pop_check(cn2);
        pop_check(int'({cl0, cl2}));

        // Shadowing: duty 3 -> 7 at cnt 5 applies from the next period.
        en = 1'b0; step(1);
        period = 16'd9; duty = 16'd3; en = 1'b1; step(1);
        step(10);
        push("shadow_cur_p0", 3); push("shadow_cur_p2", 1);
        clr(); measure(5);
        duty = 16'd7;
        measure(5);
        pop_check(cp0); pop_check(cp2);
        push("shadow_next_p0", 7); push("shadow_next_p2", 5);
        clr(); measure(10);
        pop_check(cp0); pop_check(cp2);

        // Period 9 -> 4 at cnt 3: current period still 10 cycles, next is 5.
        step(3);
        period = 16'd4;
        push("period_cur", 7);
        steps_to_cs(steps);
        pop_check(steps);
        push("period_next", 5);
        steps_to_cs(steps);
        pop_check(steps);

        // Stop mid-period with pwm_p high.
        en = 1'b0; step(1);
        period = 16'd9; duty = 16'h7FFF; en = 1'b1; step(1);
        step(24);
        push("stop_pre_p", 3);
        pop_check(int'({p0, p2}));
        en = 1'b0; step(1);
        push("stop_outs", 0);
        pop_check(int'({p0, n0, cs0, p2, n2, cs2}));
        push("stop_clamp_hold", 3);
        pop_check(int'({cl0, cl2}));
        en = 1'b1; step(1);
        restart_checks("stop");

        // Reset pulse mid-period.
        step(20);
        push("rst_pre_p", 3);
        pop_check(int'({p0, p2}));
        rst = 1'b1; step(1);
        push("rst_outs", 0);
        pop_check(int'({p0, n0, cs0, p2, n2, cs2}));
        push("rst_clamp_clear", 0);
        pop_check(int'({cl0, cl2}));
        rst = 1'b0; step(1);
        push("rst_clamp_relatch", 3);
        pop_check(int'({cl0, cl2}));
        restart_checks("rst");

        push("no_overlap", 0);
        pop_check(ovl);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
